// File: rtl/wav_dfi_hs_pkg.sv
// Shared violation ids, handshake FSM state types and helpers for the DFI
// handshake checker.
package wav_dfi_hs_pkg;

  localparam int NUM_VIOL = 14;

  localparam int V_LP_TIMEOUT        = 0;
  localparam int V_LP_ACK_NOREQ      = 1;
  // An ack still high after req has dropped is the same fault as an unrequested ack.
  localparam int V_LP_ACK_STUCK      = V_LP_ACK_NOREQ;
  localparam int V_LP_ACK_EARLY_DROP = 2;
  localparam int V_PU_REQ_WHILE_ACK  = 3;
  localparam int V_PU_TIMEOUT        = 4;
  localparam int V_PU_ACK_STUCK      = 5;
  localparam int V_PU_ACK_NOREQ      = 6;
  localparam int V_CU_ACK_NOREQ      = 7;
  localparam int V_PAIR_PU_PM        = 8;
  localparam int V_PAIR_INIT         = 9;
  localparam int V_PAIR_CU_PU        = 10;
  localparam int V_UPD_NOT_IDLE      = 11;
  localparam int V_LP_DATA_BUSY      = 12;
  localparam int V_LP_CTRL_BUSY      = 13;

  typedef enum logic [1:0] {LP_IDLE, LP_REQ, LP_ACKED, LP_DROP} lp_state_t;
  typedef enum logic [1:0] {PU_IDLE, PU_REQ, PU_ACKED} pu_state_t;

  function automatic logic [4:0] lowest_set(input logic [NUM_VIOL-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = NUM_VIOL - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wav_dfi_hs_if.sv
// DFI handshake, command and data-enable signals observed by the checker.
interface wav_dfi_hs_if #(
  parameter int NUM_PHASES = 4,
  parameter int ADDR_W     = 14
);
  logic lp_ctrl_req, lp_ctrl_ack, lp_data_req, lp_data_ack;
  logic ctrlupd_req, ctrlupd_ack, phyupd_req, phyupd_ack;
  logic phymstr_req, phymstr_ack, init_start;
  logic [NUM_PHASES*ADDR_W-1:0] address;
  logic [NUM_PHASES-1:0]        wrdata_en;
  logic [NUM_PHASES-1:0]        rddata_en;

  modport master (
    output lp_ctrl_req, lp_ctrl_ack, lp_data_req, lp_data_ack,
    output ctrlupd_req, ctrlupd_ack, phyupd_req, phyupd_ack,
    output phymstr_req, phymstr_ack, init_start,
    output address, wrdata_en, rddata_en
  );

  modport slave (
    input lp_ctrl_req, lp_ctrl_ack, lp_data_req, lp_data_ack,
    input ctrlupd_req, ctrlupd_ack, phyupd_req, phyupd_ack,
    input phymstr_req, phymstr_ack, init_start,
    input address, wrdata_en, rddata_en
  );
endinterface

// File: rtl/wav_dfi_lp_hs_fsm.sv
// Low-power req/ack handshake tracker; flags are combinational on the
// current inputs and are registered by the parent.
module wav_dfi_lp_hs_fsm
  import wav_dfi_hs_pkg::*;
#(
  parameter int TLP_RESP = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic ack,
  output logic v_timeout,
  output logic v_ack_noreq,
  output logic v_ack_early_drop
);

  localparam int CW = $clog2(TLP_RESP + 2);
  localparam logic [CW-1:0] CNT_LIM = CW'(TLP_RESP);
  localparam logic [CW-1:0] CNT_SAT = CW'(TLP_RESP + 1);

  lp_state_t       state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    v_timeout        = 1'b0;
    v_ack_noreq      = 1'b0;
    v_ack_early_drop = 1'b0;
    unique case (state)
      LP_IDLE: begin
        if (req && ack) begin
          state_nxt = LP_ACKED;
        end else if (req) begin
          state_nxt = LP_REQ;
          cnt_nxt   = CW'(1);
        end else if (ack) begin
          v_ack_noreq = 1'b1;
        end
      end
      LP_REQ: begin
        if (ack) begin
          state_nxt = LP_ACKED;
        end else if (!req) begin
          state_nxt = LP_IDLE;
        end else begin
          // Counter parks one past the limit so the timeout fires only once.
          if (cnt == CNT_LIM) v_timeout = 1'b1;
          if (cnt != CNT_SAT) cnt_nxt = cnt + 1'b1;
        end
      end
      LP_ACKED: begin
        if (!req) begin
          state_nxt = LP_DROP;
        end else if (!ack) begin
          v_ack_early_drop = 1'b1;
          state_nxt        = LP_IDLE;
        end
      end
      LP_DROP: begin
        if (ack) v_ack_noreq = 1'b1;
        state_nxt = LP_IDLE;
      end
      default: state_nxt = LP_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= LP_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/wav_dfi_hs_checker.sv
// Passive DFI handshake checker: per-type violation pulses, sticky flags,
// first-error capture and a saturating count of violating cycles.
module wav_dfi_hs_checker
  import wav_dfi_hs_pkg::*;
#(
  parameter int NUM_PHASES   = 4,
  parameter int ADDR_W       = 14,
  parameter int TLP_RESP     = 8,
  parameter int TPHYUPD_RESP = 16,
  parameter int CNT_W        = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                chk_en,
  input  logic                clr,
  wav_dfi_hs_if.slave         dfi,
  output logic [NUM_VIOL-1:0] viol_pulse,
  output logic [NUM_VIOL-1:0] viol_sticky,
  output logic                first_viol_valid,
  output logic [4:0]          first_viol_id,
  output logic [CNT_W-1:0]    viol_count
);

  localparam int PW = $clog2(TPHYUPD_RESP + 2);
  localparam logic [PW-1:0] PU_LIM = PW'(TPHYUPD_RESP);
  localparam logic [PW-1:0] PU_SAT = PW'(TPHYUPD_RESP + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  logic [NUM_PHASES*ADDR_W-1:0] addr;
  logic [NUM_PHASES-1:0]        wr_en, rd_en;
  assign addr  = dfi.address;
  assign wr_en = dfi.wrdata_en;
  assign rd_en = dfi.rddata_en;

  logic lpc_to, lpc_noreq, lpc_early, lpd_to, lpd_noreq, lpd_early;

  wav_dfi_lp_hs_fsm #(.TLP_RESP(TLP_RESP)) u_lp_ctrl (
    .clock(clock), .reset(reset), .req(dfi.lp_ctrl_req), .ack(dfi.lp_ctrl_ack),
    .v_timeout(lpc_to), .v_ack_noreq(lpc_noreq), .v_ack_early_drop(lpc_early)
  );

  wav_dfi_lp_hs_fsm #(.TLP_RESP(TLP_RESP)) u_lp_data (
    .clock(clock), .reset(reset), .req(dfi.lp_data_req), .ack(dfi.lp_data_ack),
    .v_timeout(lpd_to), .v_ack_noreq(lpd_noreq), .v_ack_early_drop(lpd_early)
  );

  pu_state_t       pu_state, pu_state_nxt;
  logic [PW-1:0]   pu_cnt, pu_cnt_nxt;
  logic            pu_req_d;
  logic            v_pu_rwa, v_pu_to, v_pu_stuck, v_pu_noreq;

  always_comb begin
    pu_state_nxt = pu_state;
    pu_cnt_nxt   = pu_cnt;
    v_pu_rwa     = 1'b0;
    v_pu_to      = 1'b0;
    v_pu_stuck   = 1'b0;
    v_pu_noreq   = 1'b0;
    unique case (pu_state)
      PU_IDLE: begin
        if (dfi.phyupd_req && !pu_req_d && dfi.phyupd_ack) v_pu_rwa = 1'b1;
        if (dfi.phyupd_req && dfi.phyupd_ack) begin
          pu_state_nxt = PU_ACKED;
        end else if (dfi.phyupd_req) begin
          pu_state_nxt = PU_REQ;
          pu_cnt_nxt   = PW'(1);
        end else if (dfi.phyupd_ack) begin
          v_pu_noreq = 1'b1;
        end
      end
      PU_REQ: begin
        if (dfi.phyupd_ack) begin
          pu_state_nxt = PU_ACKED;
        end else if (!dfi.phyupd_req) begin
          pu_state_nxt = PU_IDLE;
        end else begin
          if (pu_cnt == PU_LIM) v_pu_to = 1'b1;
          if (pu_cnt != PU_SAT) pu_cnt_nxt = pu_cnt + 1'b1;
        end
      end
      PU_ACKED: begin
        // The cycle after req falls, ack must already be low.
        if (!pu_req_d) begin
          v_pu_stuck   = dfi.phyupd_ack;
          pu_state_nxt = PU_IDLE;
        end else if (!dfi.phyupd_req && !dfi.phyupd_ack) begin
          pu_state_nxt = PU_IDLE;
        end
      end
      default: pu_state_nxt = PU_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pu_state <= PU_IDLE;
      pu_cnt   <= '0;
      pu_req_d <= 1'b0;
    end else begin
      pu_state <= pu_state_nxt;
      pu_cnt   <= pu_cnt_nxt;
      pu_req_d <= dfi.phyupd_req;
    end
  end

  logic [NUM_VIOL-1:0] det, det_g;
  logic                any_lp_req;

  always_comb begin
    any_lp_req                  = dfi.lp_ctrl_req | dfi.lp_data_req;
    det                         = '0;
    det[V_LP_TIMEOUT]           = lpc_to | lpd_to;
    det[V_LP_ACK_NOREQ]         = lpc_noreq | lpd_noreq;
    det[V_LP_ACK_EARLY_DROP]    = lpc_early | lpd_early;
    det[V_PU_REQ_WHILE_ACK]     = v_pu_rwa;
    det[V_PU_TIMEOUT]           = v_pu_to;
    det[V_PU_ACK_STUCK]         = v_pu_stuck;
    det[V_PU_ACK_NOREQ]         = v_pu_noreq;
    det[V_CU_ACK_NOREQ]         = dfi.ctrlupd_ack & ~dfi.ctrlupd_req;
    det[V_PAIR_PU_PM]           = dfi.phyupd_ack & dfi.phymstr_ack;
    det[V_PAIR_INIT]            = dfi.init_start & (dfi.phyupd_ack | dfi.phymstr_ack |
                                                    dfi.ctrlupd_req | any_lp_req);
    det[V_PAIR_CU_PU]           = dfi.ctrlupd_req & dfi.phyupd_ack;
    det[V_UPD_NOT_IDLE]         = (dfi.phyupd_ack | dfi.ctrlupd_ack) & ((|addr) | any_lp_req);
    det[V_LP_DATA_BUSY]         = dfi.lp_data_req & ((|wr_en) | (|rd_en));
    det[V_LP_CTRL_BUSY]         = dfi.lp_ctrl_req & (|addr);
    det_g                       = chk_en ? det : '0;
  end

  // Stage p0 -> p1: register detected violations into pulse/sticky/capture/count.
  always_ff @(posedge clock) begin
    if (reset) begin
      viol_pulse       <= '0;
      viol_sticky      <= '0;
      first_viol_valid <= 1'b0;
      first_viol_id    <= '0;
      viol_count       <= '0;
    end else begin
      viol_pulse  <= det_g;
      viol_sticky <= (clr ? '0 : viol_sticky) | det_g;
      if (clr || !first_viol_valid) begin
        first_viol_valid <= |det_g;
        first_viol_id    <= lowest_set(det_g);
      end
      viol_count <= sat_inc(clr ? '0 : viol_count, |det_g);
    end
  end

endmodule

// File: tb/tb_wav_dfi_hs_checker.sv
// Directed bench for the DFI handshake checker with hand-computed expectations.
module tb_wav_dfi_hs_checker;
  import wav_dfi_hs_pkg::*;

  logic                clock = 1'b0;
  logic                reset, chk_en, clr;
  logic [NUM_VIOL-1:0] viol_pulse, viol_sticky;
  logic                first_viol_valid;
  logic [4:0]          first_viol_id;
  logic [7:0]          viol_count;

  int total = 0;
  int bad   = 0;
  logic [NUM_VIOL-1:0] acc;

  wav_dfi_hs_if #(.NUM_PHASES(4), .ADDR_W(14)) dfi ();

  wav_dfi_hs_checker #(
    .NUM_PHASES(4), .ADDR_W(14), .TLP_RESP(8), .TPHYUPD_RESP(16), .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset), .chk_en(chk_en), .clr(clr), .dfi(dfi),
    .viol_pulse(viol_pulse), .viol_sticky(viol_sticky),
    .first_viol_valid(first_viol_valid), .first_viol_id(first_viol_id),
    .viol_count(viol_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    acc |= viol_pulse;
  endtask

  task automatic idle_inputs();
    dfi.lp_ctrl_req = 0; dfi.lp_ctrl_ack = 0; dfi.lp_data_req = 0; dfi.lp_data_ack = 0;
    dfi.ctrlupd_req = 0; dfi.ctrlupd_ack = 0; dfi.phyupd_req = 0; dfi.phyupd_ack = 0;
    dfi.phymstr_req = 0; dfi.phymstr_ack = 0; dfi.init_start = 0;
    dfi.address = '0; dfi.wrdata_en = '0; dfi.rddata_en = '0;
  endtask

  task automatic pulse_clr();
    clr = 1; tick(); clr = 0; acc = '0;
  endtask

  int n_hit, at_cyc;

  initial begin
    idle_inputs();
    reset = 1; chk_en = 1; clr = 0; acc = '0;
    repeat (3) tick();
    check("rst_pulse", 32'(viol_pulse), 0);
    check("rst_sticky", 32'(viol_sticky), 0);
    check("rst_valid", 32'(first_viol_valid), 0);
    check("rst_id", 32'(first_viol_id), 0);
    check("rst_count", 32'(viol_count), 0);
    reset = 0; tick(); acc = '0;

    // Clean lp_ctrl handshake.
    dfi.lp_ctrl_req = 1;
    repeat (3) tick();
    dfi.lp_ctrl_ack = 1; tick();
    dfi.lp_ctrl_req = 0; tick();
    dfi.lp_ctrl_ack = 0; tick();
    tick();
    check("lpc_clean_pulses", 32'(acc), 0);
    check("lpc_clean_count", 32'(viol_count), 0);

    // lp_data timeout: the ninth sample with req still high fires once.
    n_hit = 0; at_cyc = -1;
    dfi.lp_data_req = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (viol_pulse[V_LP_TIMEOUT]) begin n_hit++; at_cyc = i; end
    end
    check("lpd_to_once", 32'(n_hit), 1);
    check("lpd_to_cycle", 32'(at_cyc), 8);
    check("lpd_to_count", 32'(viol_count), 1);
    check("lpd_to_first_valid", 32'(first_viol_valid), 1);
    check("lpd_to_first_id", 32'(first_viol_id), V_LP_TIMEOUT);
    dfi.lp_data_req = 0; tick();
    pulse_clr();

    // phyupd ack at cycle 17 -> timeout flagged at cycle 16.
    n_hit = 0; at_cyc = -1;
    dfi.phyupd_req = 1;
    for (int k = 0; k <= 17; k++) begin
      dfi.phyupd_ack = (k == 17);
      tick();
      if (viol_pulse[V_PU_TIMEOUT]) begin n_hit++; at_cyc = k; end
    end
    dfi.phyupd_req = 0; tick();
    dfi.phyupd_ack = 0; tick();
    tick();
    check("pu_to_once", 32'(n_hit), 1);
    check("pu_to_cycle", 32'(at_cyc), 16);
    check("pu_to_sticky", 32'(viol_sticky), 32'(1) << V_PU_TIMEOUT);
    check("pu_to_first_id", 32'(first_viol_id), V_PU_TIMEOUT);
    pulse_clr();

    // phyupd ack at cycle 16 -> clean.
    dfi.phyupd_req = 1;
    for (int k = 0; k <= 16; k++) begin
      dfi.phyupd_ack = (k == 16);
      tick();
    end
    dfi.phyupd_req = 0; tick();
    dfi.phyupd_ack = 0; tick();
    tick();
    check("pu_ok_pulses", 32'(acc), 0);
    check("pu_ok_count", 32'(viol_count), 0);

    // phyupd ack with a live address, then with init_start and clr together.
    dfi.phyupd_req = 1; tick();
    dfi.phyupd_ack = 1; dfi.address = 56'h0010 << 28; tick();
    check("upd_addr_pulse", 32'(viol_pulse), 32'(1) << V_UPD_NOT_IDLE);
    dfi.init_start = 1; clr = 1; tick();
    clr = 0;
    check("upd_init_pulse", 32'(viol_pulse), (32'(1) << V_UPD_NOT_IDLE) | (32'(1) << V_PAIR_INIT));
    check("upd_init_first_id", 32'(first_viol_id), V_PAIR_INIT);
    check("upd_init_count", 32'(viol_count), 1);
    dfi.init_start = 0; dfi.address = '0; dfi.phyupd_req = 0; tick();
    dfi.phyupd_ack = 0; tick();
    check("upd_release_pulse", 32'(viol_pulse), 0);

    // chk_en gating, then re-enabled.
    chk_en = 0; dfi.ctrlupd_ack = 1; tick();
    check("chk_dis_pulse", 32'(viol_pulse), 0);
    check("chk_dis_count", 32'(viol_count), 1);
    chk_en = 1; tick();
    check("cu_noreq_pulse", 32'(viol_pulse), 32'(1) << V_CU_ACK_NOREQ);
    check("cu_noreq_count", 32'(viol_count), 2);
    dfi.ctrlupd_ack = 0;

    // clr together with fresh violations keeps only the fresh ones.
    clr = 1; dfi.phyupd_ack = 1; dfi.phymstr_ack = 1; tick();
    clr = 0; dfi.phyupd_ack = 0; dfi.phymstr_ack = 0;
    check("clr_new_sticky", 32'(viol_sticky), (32'(1) << V_PU_ACK_NOREQ) | (32'(1) << V_PAIR_PU_PM));
    check("clr_new_first_id", 32'(first_viol_id), V_PU_ACK_NOREQ);
    check("clr_new_count", 32'(viol_count), 1);
    tick();
    pulse_clr();

    // Counter saturation, then clr.
    dfi.lp_data_req = 1; dfi.wrdata_en = 4'b0100;
    repeat (300) tick();
    check("sat_count", 32'(viol_count), 255);
    check("sat_sticky", 32'(viol_sticky), (32'(1) << V_LP_DATA_BUSY) | (32'(1) << V_LP_TIMEOUT));
    check("sat_first_id", 32'(first_viol_id), V_LP_DATA_BUSY);
    dfi.lp_data_req = 0; dfi.wrdata_en = '0; clr = 1; tick();
    clr = 0;
    check("clr_pulse", 32'(viol_pulse), 0);
    check("clr_sticky", 32'(viol_sticky), 0);
    check("clr_valid", 32'(first_viol_valid), 0);
    check("clr_id", 32'(first_viol_id), 0);
    check("clr_count", 32'(viol_count), 0);

    // Reset while lp_ctrl is ACKED, with a violation pending.
    dfi.lp_ctrl_req = 1; tick();
    dfi.lp_ctrl_ack = 1; dfi.ctrlupd_ack = 1; tick();
    check("pre_rst_count", 32'(viol_count), 1);
    reset = 1; dfi.lp_ctrl_req = 0; dfi.lp_ctrl_ack = 0; dfi.ctrlupd_ack = 0; tick();
    check("mid_rst_sticky", 32'(viol_sticky), 0);
    check("mid_rst_count", 32'(viol_count), 0);
    check("mid_rst_valid", 32'(first_viol_valid), 0);
    reset = 0; acc = '0;
    dfi.lp_ctrl_req = 1; tick();
    dfi.lp_ctrl_ack = 1; tick();
    dfi.lp_ctrl_req = 0; tick();
    dfi.lp_ctrl_ack = 0; tick();
    tick();
    check("post_rst_pulses", 32'(acc), 0);
    check("post_rst_count", 32'(viol_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
